mem_arbiter: RTL and testbench

- Shares the single synchronous memory between two requesters: master 0 (cpu, high priority) and master 1 (dma/debug/video, low priority).
- The memory has one read port and one write port. Each port is arbitrated independently, so one read and one write can be granted in the same cycle.
- Master 1 is protected from starvation by a per-port wait counter.
- Sits between the cpu/peripheral masters and the memory's raddr/rdata/waddr/wdata/wr/rd pins.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_port.sv | 49 ++++
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: master indices and defaults.
package mem_arbiter_pkg;

    // Master index; also used as the registered read-data owner tag.
    typedef enum logic {
        MASTER_CPU = 1'b0,
        MASTER_AUX = 1'b1
    } master_e;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int DEFAULT_CWIDTH       = 4;

endpackage

// File: rtl/mem_arbiter_port.sv
// Two-requester fixed-priority arbiter (req0 wins) with a starvation
// counter that forces a grant to req1 after STARVE_LIMIT denied cycles.
module mem_arb_port
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CWIDTH       = DEFAULT_CWIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [CWIDTH-1:0] LIMIT = CWIDTH'(STARVE_LIMIT);

    logic [CWIDTH-1:0] wcnt;

    // Grant decision: starving req1 first, then req0, then req1; none in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req1 && (wcnt == LIMIT)) begin
                gnt1 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Wait counter: counts denied req1 cycles, saturating; clears otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt <= '0;
        end else if (req1 && !gnt1) begin
            if (wcnt != LIMIT) begin
                wcnt <= wcnt + 1'b1;
            end
        end else begin
            wcnt <= '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory (one read port, one write port) between a
// high-priority cpu master and a low-priority auxiliary master.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AWIDTH       = 16,
    parameter int DWIDTH       = 16,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CWIDTH       = DEFAULT_CWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_rreq,
    input  logic [AWIDTH-1:0] m0_raddr,
    output logic              m0_rgnt,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,
    input  logic              m0_wreq,
    input  logic [AWIDTH-1:0] m0_waddr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_wgnt,
    input  logic              m1_rreq,
    input  logic [AWIDTH-1:0] m1_raddr,
    output logic              m1_rgnt,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,
    input  logic              m1_wreq,
    input  logic [AWIDTH-1:0] m1_waddr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_wgnt,
    output logic [AWIDTH-1:0] mem_raddr_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic [AWIDTH-1:0] mem_waddr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic              mem_wr_o,
    output logic              mem_rd_o
);

    logic    rvalid_q;
    master_e owner_q;

    mem_arb_port #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CWIDTH      (CWIDTH)
    ) u_rd_port (
        .clk  (clk),
        .reset(reset),
        .req0 (m0_rreq),
        .req1 (m1_rreq),
        .gnt0 (m0_rgnt),
        .gnt1 (m1_rgnt)
    );

    mem_arb_port #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CWIDTH      (CWIDTH)
    ) u_wr_port (
        .clk  (clk),
        .reset(reset),
        .req0 (m0_wreq),
        .req1 (m1_wreq),
        .gnt0 (m0_wgnt),
        .gnt1 (m1_wgnt)
    );

    // Memory pin muxing: granted master's fields, master 0's when idle.
    always_comb begin
        mem_rd_o    = m0_rgnt | m1_rgnt;
        mem_wr_o    = m0_wgnt | m1_wgnt;
        mem_raddr_o = m1_rgnt ? m1_raddr : m0_raddr;
        mem_waddr_o = m1_wgnt ? m1_waddr : m0_waddr;
        mem_wdata_o = m1_wgnt ? m1_wdata : m0_wdata;
    end

    // Read return tracking: data arrives one cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            owner_q  <= MASTER_CPU;
        end else begin
            rvalid_q <= m0_rgnt | m1_rgnt;
            owner_q  <= m1_rgnt ? MASTER_AUX : MASTER_CPU;
        end
    end

    // Read data is broadcast; only rvalid tells the masters apart.
    always_comb begin
        m0_rvalid = rvalid_q && (owner_q == MASTER_CPU);
        m1_rvalid = rvalid_q && (owner_q == MASTER_AUX);
        m0_rdata  = mem_rdata_i;
        m1_rdata  = mem_rdata_i;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, behavioural reference,
// per-cycle comparison, and directed scenarios with literal expectations.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LIM = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          preload;
    logic          m0_rreq, m0_wreq, m1_rreq, m1_wreq;
    logic [AW-1:0] m0_raddr, m0_waddr, m1_raddr, m1_waddr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_rgnt, m0_rvalid, m0_wgnt, m1_rgnt, m1_rvalid, m1_wgnt;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_raddr_o, mem_waddr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;
    logic          mem_wr_o, mem_rd_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AWIDTH      (AW),
        .DWIDTH      (DW),
        .STARVE_LIMIT(LIM),
        .CWIDTH      (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_rreq    (m0_rreq),
        .m0_raddr   (m0_raddr),
        .m0_rgnt    (m0_rgnt),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m0_wreq    (m0_wreq),
        .m0_waddr   (m0_waddr),
        .m0_wdata   (m0_wdata),
        .m0_wgnt    (m0_wgnt),
        .m1_rreq    (m1_rreq),
        .m1_raddr   (m1_raddr),
        .m1_rgnt    (m1_rgnt),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .m1_wreq    (m1_wreq),
        .m1_waddr   (m1_waddr),
        .m1_wdata   (m1_wdata),
        .m1_wgnt    (m1_wgnt),
        .mem_raddr_o(mem_raddr_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_waddr_o(mem_waddr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_wr_o   (mem_wr_o),
        .mem_rd_o   (mem_rd_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Environment memory: synchronous read (old data on same-cycle write).
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (preload) begin
            mem[8'h10] <= 16'hAAAA;
            mem[8'h20] <= 16'hC0DE;
            mem[8'h40] <= 16'hBEEF;
        end else begin
            if (mem_rd_o) mem_rdata_i <= mem[mem_raddr_o[7:0]];
            if (mem_wr_o) mem[mem_waddr_o[7:0]] <= mem_wdata_o;
        end
    end

    // Reference model: the aux master gets the port when it has been turned
    // away LIM times in a row, or when the cpu is not asking.
    int            run_r, run_w;
    logic [DW-1:0] mm [0:255];
    logic          e_rg0, e_rg1, e_wg0, e_wg1;
    logic          e_rv, e_own;
    logic [DW-1:0] e_data;
    logic          started = 1'b0;

    always_comb begin
        e_rg1 = !reset && m1_rreq && (run_r >= LIM || !m0_rreq);
        e_rg0 = !reset && m0_rreq && !(m1_rreq && run_r >= LIM);
        e_wg1 = !reset && m1_wreq && (run_w >= LIM || !m0_wreq);
        e_wg0 = !reset && m0_wreq && !(m1_wreq && run_w >= LIM);
    end

    always @(posedge clk) begin
        started <= 1'b1;
        if (preload) begin
            mm[8'h10] <= 16'hAAAA;
            mm[8'h20] <= 16'hC0DE;
            mm[8'h40] <= 16'hBEEF;
        end else if (e_wg0 || e_wg1) begin
            mm[e_wg1 ? m1_waddr[7:0] : m0_waddr[7:0]] <= e_wg1 ? m1_wdata : m0_wdata;
        end
        e_rv  <= e_rg0 || e_rg1;
        e_own <= e_rg1;
        if (e_rg0 || e_rg1) e_data <= mm[e_rg1 ? m1_raddr[7:0] : m0_raddr[7:0]];
        if (reset) begin
            run_r <= 0;
            run_w <= 0;
        end else begin
            run_r <= (m1_rreq && !e_rg1) ? ((run_r + 1 > LIM) ? LIM : run_r + 1) : 0;
            run_w <= (m1_wreq && !e_wg1) ? ((run_w + 1 > LIM) ? LIM : run_w + 1) : 0;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("m0_rgnt", 32'(m0_rgnt), 32'(e_rg0));
            chk("m1_rgnt", 32'(m1_rgnt), 32'(e_rg1));
            chk("m0_wgnt", 32'(m0_wgnt), 32'(e_wg0));
            chk("m1_wgnt", 32'(m1_wgnt), 32'(e_wg1));
            chk("mem_rd_o", 32'(mem_rd_o), 32'(e_rg0 || e_rg1));
            chk("mem_wr_o", 32'(mem_wr_o), 32'(e_wg0 || e_wg1));
            chk("mem_raddr_o", 32'(mem_raddr_o), 32'(e_rg1 ? m1_raddr : m0_raddr));
            chk("mem_waddr_o", 32'(mem_waddr_o), 32'(e_wg1 ? m1_waddr : m0_waddr));
            chk("mem_wdata_o", 32'(mem_wdata_o), 32'(e_wg1 ? m1_wdata : m0_wdata));
            chk("m0_rvalid", 32'(m0_rvalid), 32'(e_rv && !e_own));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(e_rv && e_own));
            if (e_rv) begin
                chk("rdata", 32'(e_own ? m1_rdata : m0_rdata), 32'(e_data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_rreq = 0; m0_wreq = 0; m1_rreq = 0; m1_wreq = 0;
    endtask

    logic [9:0] pat1, pat0;
    logic [7:0] gbits, vbits, obits;
    int         first;

    initial begin
        reset = 1; preload = 1;
        idle_inputs();
        m0_raddr = '0; m0_waddr = '0; m0_wdata = '0;
        m1_raddr = '0; m1_waddr = '0; m1_wdata = '0;
        repeat (2) step();
        preload = 0;
        step();
        @(negedge clk);
        chk("reset_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("reset_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("reset_mem_wr", 32'(mem_wr_o), 32'd0);
        step();
        reset = 0;

        // Single aux read of 0x0040.
        step();
        m1_rreq = 1; m1_raddr = 16'h0040;
        @(negedge clk);
        chk("t1_m1_rgnt", 32'(m1_rgnt), 32'd1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("t1_m1_rdata", 32'(m1_rdata), 32'h0000BEEF);
        chk("t1_m0_rvalid", 32'(m0_rvalid), 32'd0);

        // Starvation: both read continuously; aux wins every 5th cycle.
        step();
        m0_rreq = 1; m0_raddr = 16'h0010;
        m1_rreq = 1; m1_raddr = 16'h0040;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat1[i] = m1_rgnt;
            pat0[i] = m0_rgnt;
            step();
        end
        idle_inputs();
        chk("t2_m1_pattern", 32'(pat1), 32'(10'b1000010000));
        chk("t2_m0_pattern", 32'(pat0), 32'(10'b0111101111));

        // cpu write and aux read in the same cycle.
        m0_wreq = 1; m0_waddr = 16'h0010; m0_wdata = 16'h1234;
        m1_rreq = 1; m1_raddr = 16'h0020;
        @(negedge clk);
        chk("t3_m0_wgnt", 32'(m0_wgnt), 32'd1);
        chk("t3_m1_rgnt", 32'(m1_rgnt), 32'd1);
        chk("t3_mem_wr", 32'(mem_wr_o), 32'd1);
        chk("t3_mem_rd", 32'(mem_rd_o), 32'd1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("t3_m1_rvalid", 32'(m1_rvalid), 32'd1);
        chk("t3_m1_rdata", 32'(m1_rdata), 32'h0000C0DE);

        // Read and write of the same address: old data, then new data.
        step();
        m0_rreq = 1; m0_raddr = 16'h0010;
        m1_wreq = 1; m1_waddr = 16'h0010; m1_wdata = 16'h5555;
        @(negedge clk);
        chk("t4_m0_rgnt", 32'(m0_rgnt), 32'd1);
        chk("t4_m1_wgnt", 32'(m1_wgnt), 32'd1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("t4_old_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t4_old_rdata", 32'(m0_rdata), 32'h00001234);
        step();
        m0_rreq = 1; m0_raddr = 16'h0010;
        step();
        idle_inputs();
        @(negedge clk);
        chk("t4_new_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t4_new_rdata", 32'(m0_rdata), 32'h00005555);

        // Reset right after a cpu read grant with aux requests pending.
        step();
        m0_rreq = 1; m0_raddr = 16'h0040;
        m1_rreq = 1; m1_raddr = 16'h0020;
        m1_wreq = 1; m1_waddr = 16'h0030; m1_wdata = 16'h7777;
        @(negedge clk);
        chk("t5_m0_rgnt", 32'(m0_rgnt), 32'd1);
        step();
        reset = 1;
        @(negedge clk);
        chk("t5_rst_m0_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t5_rst_m0_rdata", 32'(m0_rdata), 32'h0000BEEF);
        chk("t5_rst_rgnt", 32'({m0_rgnt, m1_rgnt}), 32'd0);
        chk("t5_rst_wgnt", 32'(m1_wgnt), 32'd0);
        chk("t5_rst_mem_wr", 32'(mem_wr_o), 32'd0);
        step();
        @(negedge clk);
        chk("t5_rst2_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("t5_rst2_mem_wr", 32'(mem_wr_o), 32'd0);
        step();
        reset = 0;
        first = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m1_rgnt && first < 0) first = i;
            step();
        end
        idle_inputs();
        chk("t5_m1_first_grant", 32'(first), 32'd4);

        // Alternating cpu/aux reads, one per cycle.
        m0_raddr = 16'h0010; m1_raddr = 16'h0040;
        for (int k = 0; k < 8; k++) begin
            m0_rreq = (k % 2 == 0);
            m1_rreq = (k % 2 == 1);
            @(negedge clk);
            gbits[k] = m0_rgnt | m1_rgnt;
            if (k > 0) begin
                vbits[k-1] = m0_rvalid | m1_rvalid;
                obits[k-1] = m1_rvalid;
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        vbits[7] = m0_rvalid | m1_rvalid;
        obits[7] = m1_rvalid;
        chk("t6_grants", 32'(gbits), 32'h000000FF);
        chk("t6_valids", 32'(vbits), 32'h000000FF);
        chk("t6_owners", 32'(obits), 32'h000000AA);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
